// File: rtl/microwave_timer.sv
// BCD mm:ss countdown timer: keypad entry while idle, one-second decrements while enabled.
// Optional "+30 s" key is built in when MICROWAVE_TIMER_PLUS30_EN is defined.
module microwave_timer #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clearn,
    input  logic       load,
    input  logic [3:0] digit,
    input  logic       enable,
`ifdef MICROWAVE_TIMER_PLUS30_EN
    input  logic       plus30,
`endif
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       tick
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] pre;
    logic          adv;
    logic          wrap;
    logic          load_ok;
    logic [3:0]    d_mt, d_mo, d_st, d_so;

    assign timer_done = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                        (sec_tens == 4'd0) && (sec_ones == 4'd0);
    assign adv        = enable && !timer_done;
    assign wrap       = adv && (pre == PRE_LAST);
    assign load_ok    = load && !enable && (digit <= 4'd9);

    // Borrow chain; only used when the count is non-zero, so it never underflows.
    always_comb begin
        d_so = sec_ones - 4'd1;
        d_st = sec_tens;
        d_mo = min_ones;
        d_mt = min_tens;
        if (sec_ones == 4'd0) begin
            d_so = 4'd9;
            d_st = sec_tens - 4'd1;
            if (sec_tens == 4'd0) begin
                d_st = 4'd5;
                d_mo = min_ones - 4'd1;
                if (min_ones == 4'd0) begin
                    d_mo = 4'd9;
                    d_mt = min_tens - 4'd1;
                end
            end
        end
    end

`ifdef MICROWAVE_TIMER_PLUS30_EN
    logic [3:0] st_sum;
    logic [3:0] a_mt, a_mo, a_st, a_so;

    // sec_tens may already be 6..9 after keypad entry; a single -6 carry is applied.
    always_comb begin
        st_sum = sec_tens + 4'd3;
        a_so   = sec_ones;
        a_st   = st_sum;
        a_mo   = min_ones;
        a_mt   = min_tens;
        if (st_sum >= 4'd6) begin
            a_st = st_sum - 4'd6;
            if (min_ones == 4'd9) begin
                a_mo = 4'd0;
                if (min_tens == 4'd9) begin
                    a_mt = 4'd9;
                    a_mo = 4'd9;
                    a_st = 4'd5;
                    a_so = 4'd9;
                end else begin
                    a_mt = min_tens + 4'd1;
                end
            end else begin
                a_mo = min_ones + 4'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            pre      <= '0;
            tick     <= 1'b0;
        end else if (!clearn) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            pre      <= '0;
            tick     <= 1'b0;
        end else if (load_ok) begin
            min_tens <= min_ones;
            min_ones <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= digit;
            pre      <= '0;
            tick     <= 1'b0;
`ifdef MICROWAVE_TIMER_PLUS30_EN
        end else if (plus30) begin
            // On a terminal cycle pre holds, deferring the decrement by one cycle.
            min_tens <= a_mt;
            min_ones <= a_mo;
            sec_tens <= a_st;
            sec_ones <= a_so;
            if (adv && !wrap) pre <= pre + 1'b1;
            tick     <= 1'b0;
`endif
        end else begin
            tick <= wrap;
            if (wrap) begin
                pre      <= '0;
                min_tens <= d_mt;
                min_ones <= d_mo;
                sec_tens <= d_st;
                sec_ones <= d_so;
            end else if (adv) begin
                pre <= pre + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_microwave_timer.sv
// Bench for microwave_timer: directed steps then random traffic against a
// minutes/seconds arithmetic model of the countdown.
module tb_microwave_timer;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       resetn, clearn, load, enable, plus30;
    logic [3:0] digit;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done, tick;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: minutes 0..99, seconds field 0..99, enabled-cycle phase.
    int mm, ss, phase;
    bit tick_m;

    microwave_timer #(.TICKS_PER_SEC(T)) dut (
        .clk(clk), .resetn(resetn), .clearn(clearn), .load(load),
        .digit(digit), .enable(enable),
`ifdef MICROWAVE_TIMER_PLUS30_EN
        .plus30(plus30),
`endif
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .timer_done(timer_done), .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_digits();
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic void model_reset();
        mm = 0; ss = 0; phase = 0; tick_m = 1'b0;
    endfunction

    function automatic void model_step();
        bit zero;
        bit adv;
        bit last;
        int num;
        zero   = (mm == 0) && (ss == 0);
        adv    = enable && !zero;
        last   = adv && (phase == T - 1);
        tick_m = 1'b0;
        if (!clearn) begin
            mm = 0; ss = 0; phase = 0;
        end else if (load && !enable && digit <= 4'd9) begin
            num = ((mm * 100 + ss) * 10 + int'(digit)) % 10000;
            mm = num / 100; ss = num % 100; phase = 0;
`ifdef MICROWAVE_TIMER_PLUS30_EN
        end else if (plus30) begin
            ss = ss + 30;
            if (ss >= 60) begin
                ss = ss - 60;
                mm = mm + 1;
                if (mm > 99) begin mm = 99; ss = 59; end
            end
            if (adv && !last) phase = phase + 1;
`endif
        end else if (last) begin
            phase = 0;
            tick_m = 1'b1;
            if (ss > 0) ss = ss - 1;
            else begin mm = mm - 1; ss = 59; end
        end else if (adv) begin
            phase = phase + 1;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("count", {min_tens, min_ones, sec_tens, sec_ones}, exp_digits());
        check("done", timer_done, (mm == 0 && ss == 0));
        check("tick", tick, tick_m);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic key(input logic [3:0] d);
        load = 1'b1; digit = d;
        cycle();
        load = 1'b0;
    endtask

    task automatic clear();
        clearn = 1'b0;
        cycle();
        clearn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0; clearn = 1'b1; load = 1'b0; digit = 4'd0;
        enable = 1'b0; plus30 = 1'b0;
        model_reset();
        #12;
        check("rst_count", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        check("rst_done", timer_done, 1'b1);
        check("rst_tick", tick, 1'b0);
        resetn = 1'b1;

        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        check("load_1234", {min_tens, min_ones, sec_tens, sec_ones}, 16'h1234);
        check("load_done", timer_done, 1'b0);

        // 2 s run: first decrement after T cycles, done after 2T
        clear();
        key(4'd0); key(4'd0); key(4'd0); key(4'd2);
        enable = 1'b1;
        run(T - 1);
        check("no_tick_early", tick, 1'b0);
        run(1);
        check("first_dec", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0001);
        check("first_tick", tick, 1'b1);
        run(T - 1);
        check("done_not_yet", timer_done, 1'b0);
        run(1);
        check("done_rise", timer_done, 1'b1);
        run(3);
        enable = 1'b0; run(2);
        enable = 1'b1; run(T + 1);
        check("hold_zero", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);

        // borrow chains
        enable = 1'b0;
        key(4'd1); key(4'd0); key(4'd0);
        enable = 1'b1; run(T);
        check("borrow_0100", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0059);
        enable = 1'b0;
        clear();
        key(4'd9); key(4'd0);
        enable = 1'b1; run(T);
        check("dec_0090", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0089);

        // pause/resume keeps the fractional second
        enable = 1'b0;
        clear();
        key(4'd3);
        enable = 1'b1; run(2);
        enable = 1'b0; run(10);
        enable = 1'b1; run(1);
        check("resume_no_tick", tick, 1'b0);
        run(1);
        check("resume_tick", tick, 1'b1);
        check("resume_count", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0002);
        key(4'd7);
        check("load_while_en", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0002);
        run(2);
        clear();
        check("clear_mid_run", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);

        // async reset mid-countdown
        enable = 1'b0;
        key(4'd5); key(4'd0);
        enable = 1'b1; run(3);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_count", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        check("async_rst_done", timer_done, 1'b1);
        model_reset();
        #2 resetn = 1'b1;
        enable = 1'b0;

        // invalid digits are ignored
        key(4'd1); key(4'hA); key(4'hF);
        check("bad_digit", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0001);

`ifdef MICROWAVE_TIMER_PLUS30_EN
        clear();
        key(4'd4); key(4'd5);
        plus30 = 1'b1; cycle(); plus30 = 1'b0;
        check("p30_0045", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0115);
        clear();
        key(4'd9); key(4'd9); key(4'd4); key(4'd0);
        plus30 = 1'b1; cycle(); plus30 = 1'b0;
        check("p30_sat", {min_tens, min_ones, sec_tens, sec_ones}, 16'h9959);
        clear();
        key(4'd1); key(4'd0);
        enable = 1'b1; run(T - 1);
        plus30 = 1'b1; cycle(); plus30 = 1'b0;
        check("p30_collide", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0040);
        check("p30_collide_tick", tick, 1'b0);
        run(1);
        check("p30_deferred", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0039);
        enable = 1'b0;
`endif

        // random traffic
        for (int i = 0; i < 800; i++) begin
            clearn = ($urandom_range(0, 63) != 0);
            load   = ($urandom_range(0, 5) == 0);
            digit  = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 9) == 0) enable = ~enable;
`ifdef MICROWAVE_TIMER_PLUS30_EN
            plus30 = ($urandom_range(0, 19) == 0);
`endif
            cycle();
        end
        clearn = 1'b1; load = 1'b0; plus30 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/microwave_timer.md
# microwave_timer

BCD mm:ss countdown timer for the microwave controller. It accepts keypad digits while the magnetron is off and counts down one second per prescaled tick while the magnetron is on. It drives the `timer_done` input of the magnetron set/reset logic, so it sits directly upstream of that stage. A display driver reads its four BCD digits.

## Interface
- `TICKS_PER_SEC`, default 100, clock cycles per second; must be ≥ 2.
- `clk  in  1`  system clock, all state updates on rising edge.
- `resetn  in  1`  asynchronous, active-low reset.
- `clearn  in  1`  synchronous clear, active low, from keypad Clear.
- `load  in  1`  one-cycle strobe; `digit` is valid on this cycle.
- `digit  in  4`  BCD keypad digit.
- `enable  in  1`  count enable; high while the magnetron is on.
- `plus30  in  1`  one-cycle "+30 s" strobe; present only with `MICROWAVE_TIMER_PLUS30_EN`.
- `min_tens, min_ones, sec_tens, sec_ones  out  4 each`  registered BCD count.
- `timer_done  out  1`  high when all four digits are 0.
- `tick  out  1`  one-cycle pulse on the cycle the count decrements.

## Operation
- Internal state:
  - four BCD digit registers;
  - prescaler `pre`, range 0..TICKS_PER_SEC-1.
- Per-cycle priority, highest first:
  1. `clearn` = 0
  2. `load`
  3. `plus30`
  4. decrement
- Clear: all digits become 0 and `pre` becomes 0.
- Load:
  - Accepted only when `enable` = 0 and `digit` ≤ 9. Otherwise the strobe is ignored.
  - Digits shift left: min_tens←min_ones, min_ones←sec_tens, sec_tens←sec_ones, sec_ones←digit. The old min_tens is discarded.
  - `pre` becomes 0.
  - sec_tens may hold 6..9 after entry (for example 0:90). This is legal and counts down normally.
- Prescaler:
  - Advances only when `enable` = 1 and `timer_done` = 0.
  - Holds its value while `enable` = 0, so pause and resume keep the fractional second.
  - When `pre` = TICKS_PER_SEC-1 and it advances, `pre` wraps to 0 and the count decrements on that same edge.
- Decrement is a BCD borrow chain:
  - sec_ones 0→9 with borrow; otherwise −1.
  - sec_tens 0→5 with borrow; otherwise −1.
  - min_ones 0→9 with borrow; otherwise −1.
  - min_tens −1.
  - Never decrements below 00:00.
- `timer_done` is combinational from the digit registers. It rises in the same cycle the count reaches 00:00. At that point the prescaler stops and the count holds.
- `tick` is registered. It is high for the one cycle after the decrementing edge.

## Timing
- Reset values:
  - all digits 0;
  - `pre` = 0;
  - `tick` = 0;
  - `timer_done` = 1 (count is 00:00).
- Load latency: digits visible the cycle after the `load` edge.
- With `enable` continuously high, the first decrement occurs TICKS_PER_SEC cycles after `enable` rises from a fresh load or clear.
- From N seconds loaded, `timer_done` rises exactly N·TICKS_PER_SEC cycles after `enable` rises.
- Reset asserted mid-countdown: all state returns to reset values immediately, without waiting for `clk`.
- `load` while `enable` = 1: ignored, with no change to digits or `pre`.
- `enable` rising while `timer_done` = 1: nothing happens, and `tick` stays 0.

## Configuration
- `MICROWAVE_TIMER_PLUS30_EN` defined:
  - Port `plus30` exists. The strobe is accepted in any `enable` state.
  - sec_tens += 3. If the result is ≥ 6, subtract 6 and carry +1 into minutes (BCD, min_ones 9→0 carries into min_tens).
  - If the result would exceed 99:59, the count saturates at 99:59.
- Collision with a decrement: if `plus30` coincides with the prescaler terminal cycle, `pre` holds at TICKS_PER_SEC-1. The decrement then happens on the next cycle, so no second is lost.
- Macro undefined: the `plus30` port and its logic are absent. All other behaviour is identical.

## Test plan
Benches use TICKS_PER_SEC = 4.
- Reset → all digits 0, `timer_done` = 1, `tick` = 0. Then load 1,2,3,4 → 12:34 and `timer_done` = 0.
- Load 0,0,0,2, set `enable` = 1 → first `tick` after 4 cycles, count 00:01. `timer_done` rises at cycle 8 and the count holds 00:00.
- Load 1,0,0 (01:00), run one second → 00:59 (borrow chain). Load 9,0 (00:90), run one second → 00:89.
- Pause/resume: `enable` high 2 cycles, low 10 cycles, high again → decrement occurs after 2 more enabled cycles.
  - `load` during enable is ignored.
  - `clearn` = 0 mid-run → 00:00.
  - `resetn` pulse mid-run → reset values immediately.
- With macro: 00:45 + `plus30` → 01:15; 99:40 + `plus30` → 99:59. `plus30` on the terminal prescaler cycle → count +30 that cycle, decrement on the following cycle.
- Load `digit` = 4'hA → ignored, count unchanged.
